// File: rtl/alu_mp_seq.sv
// Multi-precision sequencer: runs one NBYTES*8-bit operation through an external 8-bit ALU, LSB first.
// Latency: start accepted at edge T, done pulses in the cycle after edge T+NBYTES (NBYTES+1 cycles after start).
// Backpressure: none; start is only honoured in IDLE, and starts seen while busy are dropped, not queued.
module alu_mp_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            fn,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  co,
    output logic                  z,
    output logic [2:0]            alu_fn,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_cin,
    input  logic [7:0]            alu_out,
    input  logic                  alu_co,
    input  logic                  alu_z
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [2:0]      fn_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry;
    logic [IW-1:0]   idx;
    logic            z_acc;
    logic            last_byte;

    assign last_byte = (idx == LAST_IDX);

    // Status outputs decode directly from the state register, so both drop to 0 on reset.
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and ALU drive; the ALU bus is quiet (all zero) outside RUN.
    always_comb begin
        state_nxt = state;
        alu_fn    = 3'b000;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_cin   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                alu_fn  = fn_q;
                alu_a   = a_q[8*idx +: 8];
                alu_b   = b_q[8*idx +: 8];
                alu_cin = carry;
                if (last_byte) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand latch, byte-slice accumulation and final flag capture.
    // co/z are loaded on the last RUN edge so they are already valid while done is high,
    // and they hold until the next accepted start clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fn_q   <= 3'b000;
            a_q    <= '0;
            b_q    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            z_acc  <= 1'b0;
            result <= '0;
            co     <= 1'b0;
            z      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        fn_q   <= fn;
                        a_q    <= a;
                        b_q    <= b;
                        // Logic ops never consume a carry, so the chain starts clean.
                        carry  <= fn[2] ? 1'b0 : cin;
                        idx    <= '0;
                        z_acc  <= 1'b1;
                        result <= '0;
                        co     <= 1'b0;
                        z      <= 1'b0;
                    end
                end
                S_RUN: begin
                    result[8*idx +: 8] <= alu_out;
                    carry              <= alu_co;
                    z_acc              <= z_acc & alu_z;
                    if (last_byte) begin
                        co <= ~fn_q[2] & alu_co;
                        z  <= z_acc & alu_z;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mp_seq.sv
// Self-checking bench for alu_mp_seq: behavioural 8-bit ALU plus a whole-word reference model.
// Directed cases, randomized operations, ignored mid-run start, and reset mid-run / with start.
// Sampling on the falling edge; inputs driven 1 time unit after the rising edge.
module tb_alu_mp_seq;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [2:0]    fn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          co;
    logic          z;
    logic [2:0]    alu_fn;
    logic [7:0]    alu_a;
    logic [7:0]    alu_b;
    logic          alu_cin;
    logic [7:0]    alu_out;
    logic          alu_co;
    logic          alu_z;

    int n_chk  = 0;
    int n_pass = 0;

    alu_mp_seq #(.NBYTES(NB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .fn      (fn),
        .a       (a),
        .b       (b),
        .cin     (cin),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .co      (co),
        .z       (z),
        .alu_fn  (alu_fn),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_cin (alu_cin),
        .alu_out (alu_out),
        .alu_co  (alu_co),
        .alu_z   (alu_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit combinational ALU: bit 8 is carry for add, borrow for subtract.
    logic [8:0] alu_t;
    always_comb begin
        alu_t = 9'h000;
        case (alu_fn)
            3'b000, 3'b001: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
            3'b010, 3'b011: alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_cin};
            3'b100:         alu_t = {1'b0, alu_a & alu_b};
            3'b101:         alu_t = {1'b0, alu_a | alu_b};
            3'b110:         alu_t = {1'b0, alu_a ^ alu_b};
            default:        alu_t = {1'b0, ~(alu_a & alu_b)};
        endcase
    end
    assign alu_out = alu_t[7:0];
    assign alu_co  = alu_t[8];
    assign alu_z   = (alu_t[7:0] == 8'h00);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-word reference: plain wide arithmetic, no byte slicing.
    task automatic model(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, output logic [W-1:0] r, output logic cy, output logic zz);
        longint unsigned ax;
        longint unsigned bx;
        longint unsigned s;
        ax = longint'(x);
        bx = longint'(y);
        cy = 1'b0;
        case (f)
            3'b000, 3'b001: begin
                s  = ax + bx + longint'(c);
                r  = s[W-1:0];
                cy = (s > 64'h0000_0000_FFFF_FFFF);
            end
            3'b010, 3'b011: begin
                r  = x - y - W'(c);
                cy = ((bx + longint'(c)) > ax);
            end
            3'b100:  r = x & y;
            3'b101:  r = x | y;
            3'b110:  r = x ^ y;
            default: r = ~(x & y);
        endcase
        zz = (r == '0);
    endtask

    // One full operation from IDLE; checks latency, busy span, per-byte ALU drive and results.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic c,
                          input logic [W-1:0] er, input logic ec, input logic ez);
        int  n;
        int  nb;
        bit  seen;
        @(posedge clk); #1;
        start = 1'b1; fn = f; a = x; b = y; cin = c;
        @(posedge clk); #1;
        start = 1'b0;
        fn    = 3'($urandom_range(7));
        a     = $urandom;
        b     = $urandom;
        cin   = 1'($urandom_range(1));
        n = 0; nb = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (n == 1) begin
                check({tag, " cleared_result"}, 64'(result), 64'h0);
                check({tag, " alu_cin0"}, 64'(alu_cin), 64'(f[2] ? 1'b0 : c));
            end
            if (n <= NB && !done) begin
                check({tag, " alu_a_byte"}, 64'(alu_a), 64'(x[8*(n-1) +: 8]));
                check({tag, " alu_fn"}, 64'(alu_fn), 64'(f));
            end
            if (done) seen = 1'b1;
        end
        check({tag, " done_seen"}, 64'(seen), 64'h1);
        check({tag, " latency"}, 64'(n), 64'(NB + 1));
        check({tag, " busy_cycles"}, 64'(nb), 64'(NB + 1));
        check({tag, " result"}, 64'(result), 64'(er));
        check({tag, " co"}, 64'(co), 64'(ec));
        check({tag, " z"}, 64'(z), 64'(ez));
        @(negedge clk);
        check({tag, " post_busy"}, 64'(busy), 64'h0);
        check({tag, " post_done"}, 64'(done), 64'h0);
        check({tag, " hold_result"}, 64'(result), 64'(er));
        check({tag, " idle_alu"}, 64'({alu_fn, alu_a, alu_b, alu_cin}), 64'h0);
    endtask

    task automatic count_dones(input string tag, input int cycles);
        int cnt;
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check({tag, " no_done"}, 64'(cnt), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   f;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W-1:0] er;
        logic         ec;
        logic         ez;
        bit           seen;

        rst_n = 1'b0; start = 1'b0; fn = 3'b000; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'h0);
        check("reset done", 64'(done), 64'h0);
        check("reset result", 64'(result), 64'h0);
        check("reset co_z", 64'({co, z}), 64'h0);
        check("reset alu", 64'({alu_fn, alu_a, alu_b, alu_cin}), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed cases with hand-derived expectations.
        run_op("add_ff_1",   3'b000, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("add_ripple", 3'b001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b1);
        run_op("sub_borrow", 3'b010, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("sub_chain",  3'b010, 32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0);
        run_op("nand",       3'b111, 32'hFFFF_0000, 32'hFF00_FF00, 1'b1, 32'h00FF_FFFF, 1'b0, 1'b0);
        run_op("xor_zero",   3'b110, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1, 32'h0000_0000, 1'b0, 1'b1);

        // Randomized operations against the wide model, with some all-ones/zero operands mixed in.
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(7));
            x = (i % 5 == 0) ? 32'hFFFF_FFFF : $urandom;
            y = (i % 7 == 0) ? 32'h0000_0000 : ((i % 6 == 0) ? x : $urandom);
            c = 1'($urandom_range(1));
            model(f, x, y, c, er, ec, ez);
            run_op("rand", f, x, y, c, er, ec, ez);
        end

        // Start while busy: ignored, original operation delivered, no extra done.
        @(posedge clk); #1;
        start = 1'b1; fn = 3'b000; a = 32'h0000_0001; b = 32'h0000_0002; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1; fn = 3'b110; a = $urandom; b = $urandom; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("busy_start done_seen", 64'(seen), 64'h1);
        check("busy_start result", 64'(result), 64'h3);
        check("busy_start co_z", 64'({co, z}), 64'h0);
        count_dones("busy_start", 10);
        check("busy_start idle", 64'(busy), 64'h0);

        // Reset pulse in the middle of RUN.
        @(posedge clk); #1;
        start = 1'b1; fn = 3'b000; a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst busy", 64'(busy), 64'h0);
        check("midrst done", 64'(done), 64'h0);
        check("midrst result", 64'(result), 64'h0);
        check("midrst co_z", 64'({co, z}), 64'h0);
        check("midrst alu", 64'({alu_fn, alu_a, alu_b, alu_cin}), 64'h0);
        count_dones("midrst", 10);
        run_op("after_rst", 3'b011, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFE, 1'b0, 1'b0);

        // Reset and start in the same cycle: reset wins.
        @(posedge clk); #1;
        rst_n = 1'b0; start = 1'b1; fn = 3'b000; a = 32'h1; b = 32'h1; cin = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("rst_start busy", 64'(busy), 64'h0);
        count_dones("rst_start", 8);
        run_op("final", 3'b101, 32'h0F0F_0000, 32'h0000_F0F0, 1'b1, 32'h0F0F_F0F0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
